dkong_dma: RTL and testbench



---
 rtl/dkong_dma.sv | 244 ++++++++++++++++++++++++
 tb/tb_dkong_dma.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_dma.sv
// Simplified 8257-style two-channel DMA responder for the Donkey Kong main board.
// The CPU programs source (ch0) and destination (ch1) through the register window;
// each rising DRQ then takes the Z80 bus and copies count+1 bytes as read/write pairs.
module dkong_dma #(
    parameter int CNT_W    = 14,
    parameter bit AUTOLOAD = 1'b1
) (
    input  logic        I_CLK24M,
    input  logic        I_RESET_n,
    input  logic        I_CLK_EN,
    input  logic        I_CS_n,
    input  logic        I_RD_n,
    input  logic        I_WR_n,
    input  logic [3:0]  I_A,
    input  logic [7:0]  I_DB,
    output logic [7:0]  O_DB,
    input  logic        I_DRQ,
    output logic        O_BUSRQ_n,
    input  logic        I_BUSAK_n,
    output logic [15:0] O_AB,
    output logic [7:0]  O_DO,
    input  logic [7:0]  I_DI,
    output logic        O_RD_n,
    output logic        O_WR_n,
    output logic        O_BUSY,
    output logic        O_TC
);

    localparam logic [3:0] A_MODE = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD1,
        S_RD2,
        S_WR1,
        S_WR2,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // programmed registers (CPU side)
    logic [15:0]      r_ch0_addr;
    logic [15:0]      r_ch0_cnt;
    logic [15:0]      r_ch1_addr;
    logic [15:0]      r_ch1_cnt;
    logic [7:0]       r_mode;
    logic             r_bptr;

    // strobe history and status
    logic             r_wr_n_d;
    logic             r_stat_rd;
    logic             r_tc_flag;
    logic             r_drq_d;

    // working copies used by a running transfer
    logic [15:0]      r_src;
    logic [15:0]      r_dst;
    logic [CNT_W-1:0] r_rem;
    logic [7:0]       r_data;

    logic             w_wr_stb;
    logic             w_stat_sel;
    logic             w_drq_rise;
    logic             w_start;
    logic             w_unused;

    // Replace one byte of a 16-bit register, selected by the byte pointer.
    function automatic logic [15:0] f_load_byte(input logic [15:0] cur,
                                                input logic        hi,
                                                input logic [7:0]  d);
        f_load_byte = hi ? {d, cur[7:0]} : {cur[15:8], d};
    endfunction

    // One register write per falling edge of the CPU write strobe.
    assign w_wr_stb   = !I_CS_n && !I_WR_n && r_wr_n_d;
    assign w_stat_sel = !I_CS_n && !I_RD_n && (I_A == A_MODE);
    assign w_drq_rise = I_DRQ && !r_drq_d;
    assign w_start    = (r_state == S_IDLE) && w_drq_rise && r_mode[0];

    // Status is the only readable location; everything else reads as zero.
    assign O_DB   = w_stat_sel ? {7'b0, r_tc_flag} : 8'h00;
    assign O_BUSY = (r_state != S_IDLE);

    // Stored-but-ignored register bits.
    assign w_unused = ^{r_mode[7:1], r_ch1_cnt, r_ch0_cnt};

    // Track CPU strobe history for write edge detection and end-of-status-read.
    always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_wr_n_d  <= 1'b1;
            r_stat_rd <= 1'b0;
        end else begin
            r_wr_n_d  <= I_WR_n;
            r_stat_rd <= w_stat_sel;
        end
    end

    // CPU-programmed registers, byte pointer and mode (cleared at TC when not autoloading).
    always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_ch0_addr <= 16'h0000;
            r_ch0_cnt  <= 16'h0000;
            r_ch1_addr <= 16'h0000;
            r_ch1_cnt  <= 16'h0000;
            r_mode     <= 8'h00;
            r_bptr     <= 1'b0;
        end else begin
            if (!AUTOLOAD && I_CLK_EN && (r_state == S_DONE)) begin
                r_mode[0] <= 1'b0;
            end
            if (w_wr_stb) begin
                case (I_A)
                    4'h0: begin
                        r_ch0_addr <= f_load_byte(r_ch0_addr, r_bptr, I_DB);
                        r_bptr     <= ~r_bptr;
                    end
                    4'h1: begin
                        r_ch0_cnt  <= f_load_byte(r_ch0_cnt, r_bptr, I_DB);
                        r_bptr     <= ~r_bptr;
                    end
                    4'h2: begin
                        r_ch1_addr <= f_load_byte(r_ch1_addr, r_bptr, I_DB);
                        r_bptr     <= ~r_bptr;
                    end
                    4'h3: begin
                        r_ch1_cnt  <= f_load_byte(r_ch1_cnt, r_bptr, I_DB);
                        r_bptr     <= ~r_bptr;
                    end
                    A_MODE: begin
                        r_mode     <= I_DB;
                        r_bptr     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Terminal-count flag: set in DONE, cleared when a status read ends.
    always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_tc_flag <= 1'b0;
        end else if (I_CLK_EN && (r_state == S_DONE)) begin
            r_tc_flag <= 1'b1;
        end else if (r_stat_rd && I_RD_n) begin
            r_tc_flag <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bus outputs; states only advance on clock enables.
    always_comb begin
        w_state_nxt = r_state;
        O_BUSRQ_n   = 1'b1;
        O_RD_n      = 1'b1;
        O_WR_n      = 1'b1;
        O_AB        = 16'h0000;
        O_DO        = 8'h00;
        O_TC        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_CLK_EN && w_start) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                O_BUSRQ_n = 1'b0;
                if (I_CLK_EN && !I_BUSAK_n) w_state_nxt = S_RD1;
            end
            S_RD1: begin
                O_BUSRQ_n = 1'b0;
                O_AB      = r_src;
                O_RD_n    = 1'b0;
                if (I_CLK_EN) w_state_nxt = S_RD2;
            end
            S_RD2: begin
                O_BUSRQ_n = 1'b0;
                O_AB      = r_src;
                O_RD_n    = 1'b0;
                if (I_CLK_EN) w_state_nxt = S_WR1;
            end
            S_WR1: begin
                O_BUSRQ_n = 1'b0;
                O_AB      = r_dst;
                O_DO      = r_data;
                O_WR_n    = 1'b0;
                if (I_CLK_EN) w_state_nxt = S_WR2;
            end
            S_WR2: begin
                O_BUSRQ_n = 1'b0;
                O_AB      = r_dst;
                O_DO      = r_data;
                O_WR_n    = 1'b0;
                if (I_CLK_EN) w_state_nxt = (r_rem == '0) ? S_DONE : S_RD1;
            end
            S_DONE: begin
                O_TC = 1'b1;
                if (I_CLK_EN) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working copies: loaded at start, data latched leaving RD2, pointers stepped leaving WR2.
    always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_drq_d <= 1'b0;
            r_src   <= 16'h0000;
            r_dst   <= 16'h0000;
            r_rem   <= '0;
            r_data  <= 8'h00;
        end else if (I_CLK_EN) begin
            r_drq_d <= I_DRQ;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_src <= r_ch0_addr;
                        r_dst <= r_ch1_addr;
                        r_rem <= r_ch0_cnt[CNT_W-1:0];
                    end
                end
                S_RD2: begin
                    r_data <= I_DI;
                end
                S_WR2: begin
                    r_src <= r_src + 16'd1;
                    r_dst <= r_dst + 16'd1;
                    if (r_rem != '0) r_rem <= r_rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dkong_dma.sv
// Directed bench for dkong_dma: one autoloading instance for the main scenarios
// and one non-autoloading instance for byte-pointer and single-shot behaviour.
module tb_dkong_dma;

    logic       clk   = 1'b0;
    logic       en    = 1'b0;
    logic [1:0] div   = 2'd0;
    logic       rst_n = 1'b0;

    logic       cs_n  = 1'b1;
    logic       cs2_n = 1'b1;
    logic       rd_n  = 1'b1;
    logic       wr_n  = 1'b1;
    logic [3:0] a     = 4'h0;
    logic [7:0] db    = 8'h00;
    logic       drq   = 1'b0;
    logic       busak_n  = 1'b1;
    logic       busak2_n = 1'b0;

    logic [7:0]  db_o, db2_o;
    logic        busrq_n, busrq2_n;
    logic [15:0] ab, ab2;
    logic [7:0]  dout, dout2;
    logic [7:0]  di, di2;
    logic        mrd_n, mrd2_n, mwr_n, mwr2_n;
    logic        busy, busy2, tc, tc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Clock enable: one cycle in four.
    always @(posedge clk) begin
        div <= div + 2'd1;
        en  <= (div == 2'd3);
    end

    function automatic logic [7:0] pat(input logic [15:0] adr);
        return adr[7:0] ^ {adr[14:8], adr[15]} ^ 8'h5A;
    endfunction

    assign di  = pat(ab);
    assign di2 = pat(ab2);

    dkong_dma u_dut (
        .I_CLK24M (clk),     .I_RESET_n(rst_n),   .I_CLK_EN (en),
        .I_CS_n   (cs_n),    .I_RD_n   (rd_n),    .I_WR_n   (wr_n),
        .I_A      (a),       .I_DB     (db),      .O_DB     (db_o),
        .I_DRQ    (drq),     .O_BUSRQ_n(busrq_n), .I_BUSAK_n(busak_n),
        .O_AB     (ab),      .O_DO     (dout),    .I_DI     (di),
        .O_RD_n   (mrd_n),   .O_WR_n   (mwr_n),   .O_BUSY   (busy),
        .O_TC     (tc)
    );

    dkong_dma #(.CNT_W(14), .AUTOLOAD(1'b0)) u_dut2 (
        .I_CLK24M (clk),     .I_RESET_n(rst_n),    .I_CLK_EN (en),
        .I_CS_n   (cs2_n),   .I_RD_n   (rd_n),     .I_WR_n   (wr_n),
        .I_A      (a),       .I_DB     (db),       .O_DB     (db2_o),
        .I_DRQ    (drq),     .O_BUSRQ_n(busrq2_n), .I_BUSAK_n(busak2_n),
        .O_AB     (ab2),     .O_DO     (dout2),    .I_DI     (di2),
        .O_RD_n   (mrd2_n),  .O_WR_n   (mwr2_n),   .O_BUSY   (busy2),
        .O_TC     (tc2)
    );

    // Memory write capture and event counters.
    logic [7:0] wmem [0:65535];
    logic mon_clr = 1'b0;
    logic wr_q = 1'b1, wr2_q = 1'b1, rd_q = 1'b1, rq_q = 1'b1, rq2_q = 1'b1;
    logic tc_q = 1'b0, tc2_q = 1'b0;
    int wr_cnt = 0, wr2_cnt = 0, rd_cnt = 0, rq_cnt = 0, rq2_cnt = 0;
    int tc_cnt = 0, tc2_cnt = 0, busy_cnt = 0;

    always @(posedge clk) begin
        wr_q  <= mwr_n;   wr2_q <= mwr2_n;  rd_q  <= mrd_n;
        rq_q  <= busrq_n; rq2_q <= busrq2_n;
        tc_q  <= tc;      tc2_q <= tc2;
        if (!mwr_n)       wmem[ab]  <= dout;
        else if (!mwr2_n) wmem[ab2] <= dout2;
        if (mon_clr) begin
            wr_cnt <= 0; wr2_cnt <= 0; rd_cnt <= 0; rq_cnt <= 0; rq2_cnt <= 0;
            tc_cnt <= 0; tc2_cnt <= 0; busy_cnt <= 0;
        end else begin
            if (wr_q && !mwr_n)       wr_cnt   <= wr_cnt + 1;
            if (wr2_q && !mwr2_n)     wr2_cnt  <= wr2_cnt + 1;
            if (rd_q && !mrd_n)       rd_cnt   <= rd_cnt + 1;
            if (rq_q && !busrq_n)     rq_cnt   <= rq_cnt + 1;
            if (rq2_q && !busrq2_n)   rq2_cnt  <= rq2_cnt + 1;
            if (!tc_q && tc)          tc_cnt   <= tc_cnt + 1;
            if (!tc2_q && tc2)        tc2_cnt  <= tc2_cnt + 1;
            if (en && busy)           busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!en);
        end
        #1;
    endtask

    task automatic clr_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic cpu_wr(input int sel, input logic [3:0] adr, input logic [7:0] d);
        @(negedge clk);
        a = adr; db = d; wr_n = 1'b0;
        if (sel == 1) cs_n = 1'b0; else cs2_n = 1'b0;
        @(negedge clk); @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1; cs2_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input int sel, input logic [3:0] adr, output logic [7:0] d);
        @(negedge clk);
        a = adr; rd_n = 1'b0;
        if (sel == 1) cs_n = 1'b0; else cs2_n = 1'b0;
        @(negedge clk);
        d = (sel == 1) ? db_o : db2_o;
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1; cs2_n = 1'b1;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic wait_idle(input int sel, input int max_en);
        int k;
        k = 0;
        while (((sel == 1) ? busy : busy2) && (k < max_en)) begin
            wait_en(1);
            k++;
        end
        chk("idle_timeout", (sel == 1) ? busy : busy2, 1'b0);
    endtask

    task automatic prog(input logic [15:0] src, input logic [15:0] cnt, input logic [15:0] dst);
        cpu_wr(1, 4'h0, src[7:0]); cpu_wr(1, 4'h0, src[15:8]);
        cpu_wr(1, 4'h1, cnt[7:0]); cpu_wr(1, 4'h1, cnt[15:8]);
        cpu_wr(1, 4'h2, dst[7:0]); cpu_wr(1, 4'h2, dst[15:8]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv;
        int errs;
        int k;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq", busrq_n, 1'b1);
        chk("rst_rd",    mrd_n,   1'b1);
        chk("rst_wr",    mwr_n,   1'b1);
        chk("rst_ab",    ab,      16'h0000);
        chk("rst_do",    dout,    8'h00);
        chk("rst_db",    db_o,    8'h00);
        chk("rst_busy",  busy,    1'b0);
        chk("rst_tc",    tc,      1'b0);
        @(negedge clk); rst_n = 1'b1;

        // ---- reset in the middle of a transfer ----
        prog(16'h1000, 16'h0005, 16'h2000);
        cpu_wr(1, 4'h8, 8'h01);
        busak_n = 1'b0;
        drq = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (mwr_n && k < 200);
        chk("mid_reach_wr1", mwr_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr",    mwr_n,   1'b1);
        chk("mid_rst_busrq", busrq_n, 1'b1);
        chk("mid_rst_busy",  busy,    1'b0);
        chk("mid_rst_ab",    ab,      16'h0000);
        drq = 1'b0; busak_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        clr_mon();
        drq = 1'b1; wait_en(3); drq = 1'b0; wait_en(2);
        chk("post_rst_no_req", rq_cnt, 0);
        cpu_rd(1, 4'h8, rv);
        chk("post_rst_status", rv, 8'h00);

        // ---- main sprite copy 6900H -> 7000H, 384 bytes ----
        prog(16'h6900, 16'h017F, 16'h7000);
        cpu_wr(1, 4'h8, 8'h01);
        clr_mon();
        drq = 1'b1;
        wait_en(1);
        chk("req_latency", busrq_n, 1'b0);
        chk("req_busy",    busy,    1'b1);
        wait_en(2);
        chk("req_no_rd",   mrd_n,   1'b1);
        busak_n = 1'b0;
        drq = 1'b0;
        wait_idle(1, 2000);
        chk("main_busy_en", busy_cnt, 3 + 1536 + 1);
        chk("main_wr_cnt",  wr_cnt,   384);
        chk("main_rd_cnt",  rd_cnt,   384);
        chk("main_tc_cnt",  tc_cnt,   1);
        chk("main_busrq_off", busrq_n, 1'b1);
        errs = 0;
        for (int i = 0; i < 384; i++)
            if (wmem[16'(16'h7000 + i)] !== pat(16'(16'h6900 + i))) errs++;
        chk("main_copy_errs", errs, 0);
        chk("main_last_byte", wmem[16'h717F], pat(16'h6A7F));
        cpu_rd(1, 4'h8, rv);
        chk("main_status1", rv, 8'h01);
        cpu_rd(1, 4'h8, rv);
        chk("main_status2", rv, 8'h00);
        cpu_rd(1, 4'h1, rv);
        chk("other_offset_read", rv, 8'h00);

        // ---- count 0 with source wrap FFFFH -> 0000H ----
        prog(16'hFFFF, 16'h0000, 16'h0000);
        clr_mon();
        drq = 1'b1; wait_en(1); drq = 1'b0;
        wait_idle(1, 100);
        chk("c0_wr_cnt",   wr_cnt,   1);
        chk("c0_busy_en",  busy_cnt, 6);
        chk("c0_data",     wmem[16'h0000], pat(16'hFFFF));
        chk("c0_src_wrap", u_dut.r_src, 16'h0000);
        chk("c0_dst_next", u_dut.r_dst, 16'h0001);
        chk("c0_tc_cnt",   tc_cnt,   1);
        cpu_rd(1, 4'h8, rv);
        chk("c0_status", rv, 8'h01);
        cpu_rd(1, 4'h8, rv);

        // ---- mode disabled: no request ----
        cpu_wr(1, 4'h8, 8'h00);
        clr_mon();
        drq = 1'b1; wait_en(10); drq = 1'b0; wait_en(2);
        chk("off_no_req", rq_cnt, 0);
        chk("off_no_rd",  rd_cnt, 0);
        chk("off_no_wr",  wr_cnt, 0);

        // ---- second DRQ edge and register writes during a transfer ----
        prog(16'h6900, 16'h0003, 16'h7200);
        cpu_wr(1, 4'h8, 8'h01);
        clr_mon();
        drq = 1'b1; wait_en(1); drq = 1'b0;
        wait_en(3);
        drq = 1'b1; wait_en(1); drq = 1'b0;
        cpu_wr(1, 4'h2, 8'h00); cpu_wr(1, 4'h2, 8'h73);
        wait_idle(1, 200);
        wait_en(10);
        chk("dbl_wr_cnt", wr_cnt, 4);
        chk("dbl_req_cnt", rq_cnt, 1);
        chk("dbl_tc_cnt", tc_cnt, 1);
        chk("dbl_first",  wmem[16'h7200], pat(16'h6900));
        chk("dbl_last",   wmem[16'h7203], pat(16'h6903));
        cpu_rd(1, 4'h8, rv);
        chk("dbl_status", rv, 8'h01);
        cpu_rd(1, 4'h8, rv);

        // ---- BUSAK withheld, then mode cleared and BUSAK dropped mid-transfer ----
        prog(16'h6900, 16'h0001, 16'h7400);
        busak_n = 1'b1;
        clr_mon();
        drq = 1'b1; wait_en(1); drq = 1'b0;
        wait_en(50);
        chk("hold_busrq", busrq_n, 1'b0);
        chk("hold_busy",  busy,    1'b1);
        chk("hold_no_rd", rd_cnt,  0);
        chk("hold_no_wr", wr_cnt,  0);
        busak_n = 1'b0;
        wait_en(3);
        busak_n = 1'b1;
        cpu_wr(1, 4'h8, 8'h00);
        wait_idle(1, 200);
        chk("hold_wr_cnt", wr_cnt, 2);
        chk("hold_byte0",  wmem[16'h7400], pat(16'h6900));
        chk("hold_byte1",  wmem[16'h7401], pat(16'h6901));
        chk("hold_tc_cnt", tc_cnt, 1);
        cpu_rd(1, 4'h8, rv);

        // ---- byte pointer and single-shot mode on the non-autoload instance ----
        cpu_wr(2, 4'h0, 8'h00);
        cpu_wr(2, 4'h0, 8'h69);
        cpu_wr(2, 4'h8, 8'h01);
        cpu_wr(2, 4'h0, 8'h12);
        cpu_wr(2, 4'h8, 8'h01);
        cpu_wr(2, 4'h1, 8'h00); cpu_wr(2, 4'h1, 8'h00);
        cpu_wr(2, 4'h2, 8'h00); cpu_wr(2, 4'h2, 8'h75);
        clr_mon();
        drq = 1'b1; wait_en(1); drq = 1'b0;
        wait_idle(2, 100);
        chk("bp_wr_cnt", wr2_cnt, 1);
        chk("bp_tc_cnt", tc2_cnt, 1);
        chk("bp_data",   wmem[16'h7500], pat(16'h6912));
        chk("bp_dut1_quiet", rq_cnt, 0);
        clr_mon();
        drq = 1'b1; wait_en(4); drq = 1'b0; wait_en(4);
        chk("once_no_req", rq2_cnt, 0);
        chk("once_no_wr",  wr2_cnt, 0);
        cpu_rd(2, 4'h8, rv);
        chk("once_status1", rv, 8'h01);
        cpu_rd(2, 4'h8, rv);
        chk("once_status2", rv, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
